// File: rtl/branch_decider_chooser_pkg.sv
// Shared types and constants for the fetch-stage branch decider chooser.
// The top module re-derives index/counter widths from its own parameters;
// the values here are the default build.
package branch_decider_chooser_pkg;

   localparam int PC_WIDTH                = 32;
   localparam int CHOOSER_ENTRY_NUM       = 512;
   localparam int CHOOSER_INDEX_BIT_WIDTH = $clog2(CHOOSER_ENTRY_NUM);
   localparam int CHOOSER_CNT_WIDTH       = 2;

   typedef logic [PC_WIDTH-1:0]                PC_Path;
   typedef logic [CHOOSER_INDEX_BIT_WIDTH-1:0] ChooserIndexPath;
   typedef logic [CHOOSER_CNT_WIDTH-1:0]       ChooserCntPath;

   // Chooser FSM encoding
   localparam logic [0:0] ST_INIT  = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   // Word-aligned PC to table index (default geometry)
   function automatic ChooserIndexPath ToChooserIndex(input PC_Path pc);
      return pc[CHOOSER_INDEX_BIT_WIDTH+1:2];
   endfunction

endpackage

// File: rtl/branch_chooser_table.sv
// Chooser counter storage: flop array, RD_PORTS combinational read ports and
// one write port. Reads of the address being written this cycle return the
// new data, which gives both lookup write-first and update forwarding.
module branch_chooser_table #(
   parameter int RD_PORTS  = 3,
   parameter int ENTRY_NUM = 512,
   parameter int IDX_W     = 9,
   parameter int CNT_W     = 2
) (
   input  logic                      clk,
   input  logic                      we_i,
   input  logic [IDX_W-1:0]          waddr_i,
   input  logic [CNT_W-1:0]          wdata_i,
   input  logic [RD_PORTS*IDX_W-1:0] raddr_i,
   output logic [RD_PORTS*CNT_W-1:0] rdata_o
);

   logic [CNT_W-1:0] mem_q [ENTRY_NUM];

   // Single write port; contents are initialised by the sweep, not by reset
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   generate
      for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
         logic [IDX_W-1:0] ra;
         assign ra = raddr_i[gi*IDX_W +: IDX_W];
         assign rdata_o[gi*CNT_W +: CNT_W] = (we_i && (waddr_i == ra)) ? wdata_i : mem_q[ra];
      end
   endgenerate

endmodule

// File: rtl/branch_decider_chooser.sv
// Tournament chooser between BTB+PHT and AXBTB predictions per fetch lane.
// Optional statistics counters: define BRANCH_DECIDER_STATS_EN.
module branch_decider_chooser
   import branch_decider_chooser_pkg::*;
#(
   parameter int FETCH_WIDTH       = 2,
   parameter int CHOOSER_ENTRY_NUM = 512,
   parameter int CHOOSER_CNT_WIDTH = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            rstStart_i,
   input  logic                            rdEn_i,
   input  logic [FETCH_WIDTH*PC_WIDTH-1:0] rdPC_i,
   input  logic [FETCH_WIDTH-1:0]          btbHit_i,
   input  logic [FETCH_WIDTH*PC_WIDTH-1:0] btbOut_i,
   input  logic [FETCH_WIDTH-1:0]          brPredTaken_i,
   input  logic [FETCH_WIDTH-1:0]          axbtbHit_i,
   input  logic [FETCH_WIDTH*PC_WIDTH-1:0] axbtbOut_i,
   input  logic [FETCH_WIDTH-1:0]          axreadIsCondBr_i,
   output logic [FETCH_WIDTH-1:0]          brDecidTaken_o,
   output logic [FETCH_WIDTH*PC_WIDTH-1:0] brDecidTarget_o,
   output logic [FETCH_WIDTH-1:0]          decidUseAx_o,
   input  logic                            updEn_i,
   input  logic [PC_WIDTH-1:0]             updPC_i,
   input  logic                            updBtbCorrect_i,
   input  logic                            updAxCorrect_i,
   output logic                            initBusy_o
`ifdef BRANCH_DECIDER_STATS_EN
   ,
   output logic [31:0]                     statAxChosen_o,
   output logic [31:0]                     statAxChosenCorrect_o,
   output logic [31:0]                     statDisagree_o
`endif
);

   localparam int IDX_W = $clog2(CHOOSER_ENTRY_NUM);
   localparam int CNT_W = CHOOSER_CNT_WIDTH;
   localparam int RD_PORTS = FETCH_WIDTH + 1;
   localparam logic [CNT_W-1:0] INIT_VALUE = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [IDX_W-1:0] PTR_LAST   = IDX_W'(CHOOSER_ENTRY_NUM - 1);

   logic [0:0]             state_q, state_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic                   init_d1_q;
   logic [FETCH_WIDTH-1:0] sel_q, sel_d;
   logic [FETCH_WIDTH-1:0] rd_msb;

   logic                   u1_valid_q, u1_btbc_q, u1_axc_q;
   logic [IDX_W-1:0]       u1_idx_q;
   logic [CNT_W-1:0]       u1_cnt_q, u1_new;
   logic                   u1_inc, u1_dec, upd_accept;

   logic                      tbl_we;
   logic [IDX_W-1:0]          tbl_waddr;
   logic [CNT_W-1:0]          tbl_wdata;
   logic [RD_PORTS*IDX_W-1:0] rd_idx;
   logic [RD_PORTS*CNT_W-1:0] rd_cnt;

   logic unused_upd;
   assign unused_upd = ^{updPC_i[PC_WIDTH-1:IDX_W+2], updPC_i[1:0]};

   assign initBusy_o = (state_q == ST_INIT);
   assign upd_accept = updEn_i && (state_q == ST_READY);

   // Sweep sequencing: INIT walks every entry once, rstStart re-enters INIT
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == ST_INIT) begin
         ptr_d = ptr_q + IDX_W'(1);
         if (ptr_q == PTR_LAST) state_d = ST_READY;
      end else if (rstStart_i) begin
         state_d = ST_INIT;
         ptr_d   = '0;
      end
   end

   // U1 saturating update; no write when the counter would not change
   always_comb begin
      u1_inc = u1_valid_q && u1_axc_q && !u1_btbc_q && (u1_cnt_q != CNT_MAX);
      u1_dec = u1_valid_q && u1_btbc_q && !u1_axc_q && (u1_cnt_q != '0);
      u1_new = u1_cnt_q;
      if (u1_inc)      u1_new = u1_cnt_q + CNT_W'(1);
      else if (u1_dec) u1_new = u1_cnt_q - CNT_W'(1);
   end

   // Write port arbitration: the init sweep always wins over training
   always_comb begin
      tbl_we    = (state_q == ST_INIT) || u1_inc || u1_dec;
      tbl_waddr = (state_q == ST_INIT) ? ptr_q : u1_idx_q;
      tbl_wdata = (state_q == ST_INIT) ? INIT_VALUE : u1_new;
   end

   // Registered lane selects: cleared during and just after the sweep
   always_comb begin
      sel_d = sel_q;
      if ((state_q == ST_INIT) || init_d1_q) sel_d = '0;
      else if (rdEn_i)                        sel_d = rd_msb;
   end

   // Control state, lookup selects and the U0->U1 pipeline register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_INIT;
         ptr_q      <= '0;
         init_d1_q  <= 1'b1;
         sel_q      <= '0;
         u1_valid_q <= 1'b0;
         u1_idx_q   <= '0;
         u1_cnt_q   <= '0;
         u1_btbc_q  <= 1'b0;
         u1_axc_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         init_d1_q  <= (state_q == ST_INIT);
         sel_q      <= sel_d;
         u1_valid_q <= upd_accept;
         if (upd_accept) begin
            u1_idx_q  <= updPC_i[IDX_W+1:2];
            u1_cnt_q  <= rd_cnt[FETCH_WIDTH*CNT_W +: CNT_W];
            u1_btbc_q <= updBtbCorrect_i;
            u1_axc_q  <= updAxCorrect_i;
         end
      end
   end

   // Last read port belongs to the update pipeline (U0)
   assign rd_idx[FETCH_WIDTH*IDX_W +: IDX_W] = updPC_i[IDX_W+1:2];

   generate
      for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
         logic [PC_WIDTH-1:0] rd_pc;
         logic                use_ax;
         logic                unused_lane;

         assign rd_pc  = rdPC_i[gi*PC_WIDTH +: PC_WIDTH];
         assign rd_idx[gi*IDX_W +: IDX_W] = rd_pc[IDX_W+1:2];
         assign rd_msb[gi] = rd_cnt[gi*CNT_W + CNT_W - 1];

         // A chosen AXBTB hit is always predicted taken
         assign use_ax = sel_q[gi] && axbtbHit_i[gi];
         assign brDecidTaken_o[gi] = use_ax ? 1'b1 : (btbHit_i[gi] && brPredTaken_i[gi]);
         assign brDecidTarget_o[gi*PC_WIDTH +: PC_WIDTH] =
            use_ax ? axbtbOut_i[gi*PC_WIDTH +: PC_WIDTH] : btbOut_i[gi*PC_WIDTH +: PC_WIDTH];
         assign decidUseAx_o[gi] = use_ax;
         assign unused_lane = ^{rd_pc[PC_WIDTH-1:IDX_W+2], rd_pc[1:0], axreadIsCondBr_i[gi]};
      end
   endgenerate

   branch_chooser_table #(
      .RD_PORTS  (RD_PORTS),
      .ENTRY_NUM (CHOOSER_ENTRY_NUM),
      .IDX_W     (IDX_W),
      .CNT_W     (CNT_W)
   ) u_table (
      .clk     (clk),
      .we_i    (tbl_we),
      .waddr_i (tbl_waddr),
      .wdata_i (tbl_wdata),
      .raddr_i (rd_idx),
      .rdata_o (rd_cnt)
   );

`ifdef BRANCH_DECIDER_STATS_EN
   logic [31:0] stat_ax_chosen_q, stat_ax_correct_q, stat_disagree_q;

   // Statistics sampled at U1 from the pre-update counter value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_ax_chosen_q  <= '0;
         stat_ax_correct_q <= '0;
         stat_disagree_q   <= '0;
      end else if (rstStart_i) begin
         stat_ax_chosen_q  <= '0;
         stat_ax_correct_q <= '0;
         stat_disagree_q   <= '0;
      end else if (u1_valid_q) begin
         if (u1_cnt_q[CNT_W-1])             stat_ax_chosen_q  <= stat_ax_chosen_q + 32'd1;
         if (u1_cnt_q[CNT_W-1] && u1_axc_q) stat_ax_correct_q <= stat_ax_correct_q + 32'd1;
         if (u1_btbc_q != u1_axc_q)         stat_disagree_q   <= stat_disagree_q + 32'd1;
      end
   end

   assign statAxChosen_o        = stat_ax_chosen_q;
   assign statAxChosenCorrect_o = stat_ax_correct_q;
   assign statDisagree_o        = stat_disagree_q;
`endif

endmodule

// File: doc/branch_decider_chooser.md
Name: branch_decider_chooser

Overview:
- Parametrised successor of the fetch-stage branch decider.
- Per-PC tournament table of saturating counters chooses, per fetch lane, between the conventional BTB+PHT prediction and the approximate BTB (AXBTB) prediction.
- Lookup is issued in NextPC stage; the decision is produced in Fetch stage alongside the BTB/AXBTB outputs.
- Resolved-branch feedback trains the counters through a two-stage read-modify-write pipeline. A power-on sweep initialises the table.

Parameters:
FETCH_WIDTH, 2, number of fetch lanes decided per cycle
CHOOSER_ENTRY_NUM, 512, table entries (power of two)
CHOOSER_CNT_WIDTH, 2, saturating counter width (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rstStart  in  1  one-cycle pulse starting the init sweep
rdEn  in  1  lookup enable (NextPC stage)
rdPC  in  PC_Path[FETCH_WIDTH]  lookup PCs (NextPC stage)
btbHit  in  [FETCH_WIDTH]  BTB hit (Fetch stage)
btbOut  in  PC_Path[FETCH_WIDTH]  BTB target
brPredTaken  in  [FETCH_WIDTH]  PHT taken
axbtbHit  in  [FETCH_WIDTH]  AXBTB hit
axbtbOut  in  PC_Path[FETCH_WIDTH]  AXBTB target
axreadIsCondBr  in  [FETCH_WIDTH]  AXBTB entry is conditional branch
brDecidTaken  out  [FETCH_WIDTH]  final taken decision
brDecidTarget  out  PC_Path[FETCH_WIDTH]  final target
decidUseAx  out  [FETCH_WIDTH]  chooser selected AXBTB (carried downstream)
updEn  in  1  resolved-branch update valid
updPC  in  PC_Path  resolved branch PC
updBtbCorrect  in  1  BTB/PHT prediction was correct
updAxCorrect  in  1  AXBTB prediction was correct
initBusy  out  1  init sweep in progress

Behaviour:
- Index = PC[CHOOSER_INDEX_BIT_WIDTH+1:2], where CHOOSER_INDEX_BIT_WIDTH = $clog2(CHOOSER_ENTRY_NUM).
- Counter MSB = 1 selects AXBTB. INIT_VALUE = 2^(CNT_WIDTH-1)-1 (weakly BTB).
- FSM states: INIT, READY. The state, sweep pointer, pipeline valids and registered lookups reset asynchronously on rst; the table array is not reset.
  - rst -> INIT, ptr=0. rstStart while READY -> INIT, ptr=0.
  - INIT writes INIT_VALUE to entry ptr each cycle, ptr++; at ptr==CHOOSER_ENTRY_NUM-1, write then go to READY.
  - initBusy=1 in INIT.
- Lookup, 1-cycle latency:
  - rdEn at cycle t registers the counter MSB per lane; it is used at t+1.
  - If rdEn=0, the previous registered value is held.
  - While in INIT, or on the first cycle after INIT, the registered select is forced to 0.
- Decision per lane (combinational from registered select and current inputs):
  - useAx = sel & axbtbHit.
  - brDecidTaken = useAx ? axreadIsCondBr|1 : (btbHit & brPredTaken). An AXBTB hit is always taken when chosen.
  - brDecidTarget = useAx ? axbtbOut : btbOut.
  - decidUseAx = useAx.
- Reset values of outputs: brDecidTaken=0, brDecidTarget=0, decidUseAx=0, initBusy=1.
- Update pipeline:
  - U0 (cycle of updEn): latch index and flags, read counter.
  - U1: compute and write.
  - axCorrect & !btbCorrect -> +1, saturating at max.
  - btbCorrect & !axCorrect -> -1, saturating at 0.
  - Otherwise no write.
- Forwarding: if U0 reads the index that U1 is writing in the same cycle, U0 uses the U1 result. Back-to-back updates to the same entry therefore accumulate.
- Read/write collision: a lookup of the index written by U1 in the same cycle returns the new value (write-first).
- Updates arriving in INIT are dropped; the INIT write port has priority.
- rst mid-sweep or mid-update: the pipeline is flushed and the sweep restarts from 0.
- All lanes read independently; identical lane indices are legal.

Optional Feature:
- Macro: BRANCH_DECIDER_STATS_EN.
- When defined: 32-bit counters statAxChosen, statAxChosenCorrect and statDisagree, plus output ports for them.
  - statAxChosen increments on each U1 where the counter MSB is 1.
  - statAxChosenCorrect increments on each U1 where the counter MSB is 1 and updAxCorrect.
  - statDisagree increments on each U1 where updBtbCorrect != updAxCorrect.
  - All three wrap at 2^32, reset to 0 on rst, and clear on rstStart.
- When undefined: no counters and no extra ports.

Decomposition:
- FetchUnitTypes holds CHOOSER_ENTRY_NUM, CHOOSER_INDEX_BIT_WIDTH, CHOOSER_CNT_WIDTH, ChooserIndexPath, ChooserCntPath and the ToChooserIndex function.
- FetchStageIF gains a BranchDeciderChooser modport.
- One sub-module: branch_chooser_table, a flop array with FETCH_WIDTH+1 read ports and 1 write port.

Test Plan:
- rst, then rstStart -> initBusy=1 for exactly 512 cycles. Every entry reads 1, and brDecidTarget equals btbOut with AXBTB hitting.
- updPC=0x1000 with ax-correct/btb-wrong ×2 back-to-back -> counter 1→2→3 via forwarding. A lookup of 0x1000 then selects axbtbOut=0x2000.
- Counter at 3 plus a fourth ax-correct update -> stays 3. Five btb-correct updates -> saturates at 0 and selects btbOut.
- Lookup and U1 write to the same index in the same cycle -> the next-cycle decision reflects the new counter (write-first).
- Lanes 0 and 1 at 0x1000 and 0x1004 with only 0x1000 trained -> lane 0 uses AXBTB, lane 1 uses BTB. axbtbHit=0 on lane 0 -> falls back to btbHit & brPredTaken.
- rst asserted during the sweep at ptr=200 -> outputs return to reset values and the sweep restarts at 0. An update issued during INIT changes no entry.
